// File: rtl/pc_update_unit.sv
// Program-counter register and next-PC selector for the fetch stage, with a BOOT/FETCH/HALTED sequencer.
// Optional feature: define PC_ALIGN_CHECK_EN to trap misaligned targets (hold PC, sticky error, halt).
module pc_update_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] STEP     = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] jump_addr,
  input  logic [31:0] branch_offset,
  input  logic [31:0] reg_target,
  input  logic [1:0]  pc_sel,
  input  logic        take_branch,
  input  logic        stall,
  input  logic        halt,
  input  logic        fetch_ready,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [3:0]  pc_high4,
  output logic        fetch_valid,
  output logic        halted,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SEL_REG    = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        err_q, err_d;
  logic [31:0] next_pc;
  logic        upd;
  logic        misalign;

  // Word offset scaled to bytes; sum wraps modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                input logic signed [31:0] woff);
    logic signed [31:0] byte_off;
    byte_off = woff <<< 2;
    return base + byte_off;
  endfunction

  assign pc_out   = pc_q;
  assign pc_plus4 = pc_q + STEP;
  assign pc_high4 = pc_plus4[31:28];

  assign upd = (state_q == S_FETCH) & fetch_ready & ~stall;

  always_comb begin
    next_pc = pc_plus4;
    case (pc_sel)
      SEL_SEQ:    next_pc = pc_plus4;
      SEL_BRANCH: next_pc = take_branch ? branch_target(pc_plus4, branch_offset) : pc_plus4;
      SEL_JUMP:   next_pc = jump_addr;
      SEL_REG:    next_pc = reg_target;
      default:    next_pc = pc_plus4;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  assign misalign = upd & (next_pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q | misalign;
    if (upd && !misalign) begin
      pc_d = next_pc;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:   state_d = S_FETCH;
      S_FETCH:  if (upd && (misalign || halt)) state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    fetch_valid  = 1'b0;
    halted       = 1'b0;
    misalign_err = err_q;
    case (state_q)
      S_FETCH:  fetch_valid = 1'b1;
      S_HALTED: halted      = 1'b1;
      default:  ;
    endcase
  end

endmodule
